// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues word reads to instruction memory, strobes the IR on
// response, absorbs mid-fetch redirects by draining stale responses, and flags misaligned PCs.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] pc_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        ir_load,
    output logic [31:0] ir_data,
    output logic        fetch_done,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      state, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] next_q, next_d;
    logic [31:0] count_q;
    logic        fault_q, fault_d;
    logic        launch;
    logic [31:0] launch_pc;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        next_d    = next_q;
        fault_d   = 1'b0;
        ir_load   = 1'b0;
        launch    = 1'b0;
        launch_pc = redirect_pc;

        case (state)
            IDLE: begin
                if (fetch_req) begin
                    if (pc_in[1:0] == 2'b00) begin
                        addr_d  = pc_in;
                        state_d = FETCH;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (imem_resp && !redirect) begin
                    ir_load = 1'b1;
                    state_d = IDLE;
                end else if (imem_resp) begin
                    launch = 1'b1;
                end else if (redirect) begin
                    // The in-flight read cannot be withdrawn, so park the target until it returns.
                    next_d  = redirect_pc;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_resp) begin
                    launch    = 1'b1;
                    launch_pc = redirect ? redirect_pc : next_q;
                end else if (redirect) begin
                    next_d = redirect_pc;
                end
            end
            default: state_d = IDLE;
        endcase

        // A redirect target is checked for alignment only when it is about to be read.
        if (launch) begin
            if (launch_pc[1:0] == 2'b00) begin
                addr_d  = launch_pc;
                state_d = FETCH;
            end else begin
                fault_d = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            next_q  <= '0;
            count_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_d;
            addr_q  <= addr_d;
            next_q  <= next_d;
            fault_q <= fault_d;
            if (ir_load) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign imem_read    = (state != IDLE);
    assign imem_address = addr_q;
    assign ir_data      = imem_rdata;
    assign fetch_done   = ir_load;
    assign fetch_fault  = fault_q;
    assign fetch_count  = count_q;

endmodule
